// File: rtl/muldiv_sched.sv
// HI/LO owner and sequencer for the shared multiplier and divider cores.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, drives start pulses, commits results and stalls the PC.
module muldiv_sched #(
    parameter int MUL_LAT     = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        err
);

    localparam int              TW        = $clog2(DIV_TIMEOUT + 1);
    localparam logic [3:0]      MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL_WAIT  = 3'd1,
        S_DIV_ISSUE = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   opa_q, opa_d, opb_q, opb_d;
    logic          sgn_q, sgn_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          mul_start_q, mul_start_d;
    logic          div_start_q, div_start_d;
    logic          ext_req_s;

    assign ext_req_s = op_valid | rd_hi | rd_lo;

    // Next-state, result capture and combinational stall
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        mul_start_d = 1'b0;
        div_start_d = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op)
                        3'b000, 3'b001: begin
                            opa_d       = src_a;
                            opb_d       = src_b;
                            sgn_d       = ~op[0];
                            stall       = 1'b1;
                            cnt_d       = MUL_LAT_C;
                            mul_start_d = 1'b1;
                            state_d     = S_MUL_WAIT;
                        end
                        3'b010, 3'b011: begin
                            opa_d = src_a;
                            opb_d = src_b;
                            sgn_d = ~op[0];
                            stall = 1'b1;
                            // Divide by zero bypasses the core with fixed results
                            if (src_b == 32'd0) begin
                                hi_d    = src_a;
                                lo_d    = 32'hFFFF_FFFF;
                                state_d = S_DONE;
                            end else begin
                                div_start_d = 1'b1;
                                state_d     = S_DIV_ISSUE;
                            end
                        end
                        3'b100:  hi_d = src_a;
                        3'b101:  lo_d = src_a;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL_WAIT: begin
                stall = ext_req_s;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = mul_p[63:32];
                    lo_d    = mul_p[31:0];
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL_WAIT;
                end
            end
            S_DIV_ISSUE: begin
                stall   = ext_req_s;
                tmo_d   = '0;
                state_d = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                stall = ext_req_s;
                // The core raises busy one cycle after start, so the first wait cycle is blind
                if ((tmo_q != '0) && !div_busy) begin
                    hi_d    = div_r;
                    lo_d    = div_q;
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            sgn_q       <= 1'b0;
            cnt_q       <= 4'd0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sgn_q       <= sgn_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            mul_start_q <= mul_start_d;
            div_start_q <= div_start_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign mul_start    = mul_start_q;
    assign mul_signed   = sgn_q;
    assign mul_a        = opa_q;
    assign mul_b        = opb_q;
    assign div_start    = div_start_q;
    assign div_signed   = sgn_q;
    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;
    assign err          = err_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized bench for muldiv_sched: transaction-level reference model plus
// behavioural multiplier/divider cores, checked every cycle on the falling edge.
module tb_muldiv_sched;
    localparam int MUL_LAT     = 1;
    localparam int DIV_TIMEOUT = 64;
    localparam int NEVER       = 1000;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk, rst, op_valid, rd_hi, rd_lo;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, busy, mul_start, mul_signed, div_start, div_signed, div_busy, err;
    logic [31:0] hi_out, lo_out, mul_a, mul_b, div_dividend, div_divisor, div_q, div_r;
    logic [63:0] mul_p;

    muldiv_sched #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .stall(stall), .busy(busy), .hi_out(hi_out), .lo_out(lo_out),
        .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .div_start(div_start), .div_signed(div_signed), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_busy(div_busy), .div_q(div_q), .div_r(div_r), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt = 0;
    int div_cnt   = 0;
    bit check_en  = 1'b0;
    logic        exp_stall, exp_busy, exp_mul_start, exp_div_start, exp_err;
    logic [31:0] exp_hi, exp_lo;

    function automatic logic [63:0] mul_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = 64'($signed(a));
            sb = 64'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        return 64'(sa * sb);
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = 64'($signed(a));
            sb = 64'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Multiplier core stand-in: product valid only in the cycle the latency allows
    always_comb begin
        if (mul_start) mul_p = mul_ref(mul_signed, mul_a, mul_b);
        else           mul_p = 64'hDEAD_BEEF_0BAD_F00D;
    end

    // Divider core stand-in: busy from the cycle after start for cur_div_lat cycles
    int          cur_div_lat = 0;
    int          dcnt = 0;
    logic [63:0] dqr = 64'd0;
    always @(posedge clk) begin
        if (div_start) begin
            dqr  <= div_ref(div_signed, div_dividend, div_divisor);
            dcnt <= cur_div_lat;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign div_busy = (dcnt > 0);
    assign div_q    = div_busy ? 32'hBAD0_BAD0 : dqr[31:0];
    assign div_r    = div_busy ? 32'h0BAD_0BAD : dqr[63:32];

    // Single compare process against the model expectations
    always @(negedge clk) begin
        if (check_en) begin
            check("stall", 64'(stall), 64'(exp_stall));
            check("busy", 64'(busy), 64'(exp_busy));
            check("hi_out", 64'(hi_out), 64'(exp_hi));
            check("lo_out", 64'(lo_out), 64'(exp_lo));
            check("err", 64'(err), 64'(exp_err));
            check("mul_start", 64'(mul_start), 64'(exp_mul_start));
            check("div_start", 64'(div_start), 64'(exp_div_start));
            if (stall) stall_cnt++;
            if (div_start) div_cnt++;
        end
    end

    task automatic idle_cycle(input logic rh, input logic rl);
        op_valid = 1'b0; op = 3'($urandom_range(0, 7));
        src_a = $urandom; src_b = $urandom; rd_hi = rh; rd_lo = rl;
        exp_stall = 1'b0; exp_busy = 1'b0; exp_mul_start = 1'b0; exp_div_start = 1'b0;
        @(posedge clk); #1;
    endtask

    // mode 0: instruction held; 1: random requests during the wait; 2: MFHI waiting behind it
    task automatic run_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int dlat, input int mode);
        int n, ck;
        logic [31:0] nh, nl;
        logic ne, is_mul, is_div;
        nh = exp_hi; nl = exp_lo; ne = exp_err; n = 0;
        is_mul = (opc[2:1] == 2'b00);
        is_div = (opc[2:1] == 2'b01);
        if (is_mul) begin
            {nh, nl} = mul_ref(~opc[0], a, b);
            n = MUL_LAT + 1;
        end else if (is_div && b == 32'd0) begin
            nh = a; nl = 32'hFFFF_FFFF; n = 1;
        end else if (is_div) begin
            if (dlat >= DIV_TIMEOUT) begin
                ne = 1'b1; n = DIV_TIMEOUT + 2;
            end else begin
                {nh, nl} = div_ref(~opc[0], a, b);
                n = ((dlat < 1) ? 1 : dlat) + 3;
            end
        end else if (opc == OP_MTHI) begin
            nh = a;
        end else if (opc == OP_MTLO) begin
            nl = a;
        end
        cur_div_lat = dlat;
        ck = (n == 0) ? 0 : n - 1;
        for (int k = 0; k <= n; k++) begin
            if (k == 0) begin
                op_valid = 1'b1; op = opc; src_a = a; src_b = b;
                rd_hi = 1'($urandom_range(0, 1)); rd_lo = 1'($urandom_range(0, 1));
            end else begin
                src_a = $urandom; src_b = $urandom;
                case (mode)
                    0: begin op_valid = 1'b1; rd_hi = 1'b0; rd_lo = 1'b0; end
                    1: begin
                        op_valid = 1'($urandom_range(0, 1));
                        rd_hi = 1'($urandom_range(0, 1)); rd_lo = 1'($urandom_range(0, 1));
                    end
                    default: begin op_valid = 1'b0; rd_hi = 1'b1; rd_lo = 1'b0; end
                endcase
            end
            exp_busy      = (n > 0) && (k >= 1);
            exp_stall     = (n > 0) && ((k == 0) || ((k < n) && (op_valid || rd_hi || rd_lo)));
            exp_mul_start = is_mul && (k == 1);
            exp_div_start = is_div && (b != 32'd0) && (k == 1);
            @(posedge clk); #1;
            if (k == ck) begin
                exp_hi = nh; exp_lo = nl; exp_err = ne;
            end
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        rd_hi = 1'b0; rd_lo = 1'b0;
        exp_stall = 1'b0; exp_busy = 1'b0; exp_mul_start = 1'b0; exp_div_start = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle(1'b0, 1'b0);

        // MTHI / MTLO then MFLO: no stall
        stall_cnt = 0;
        run_op(OP_MTHI, 32'h1234, 32'd0, 0, 0);
        run_op(OP_MTLO, 32'hABCD, 32'd0, 0, 0);
        idle_cycle(1'b0, 1'b1);
        check("t1_hi", 64'(hi_out), 64'h1234);
        check("t1_lo", 64'(lo_out), 64'hABCD);
        check("t1_stalls", 64'(stall_cnt), 64'd0);

        // MULT -3 x 7
        stall_cnt = 0;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("t2_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("t2_lo", 64'(lo_out), 64'hFFFF_FFEB);
        check("t2_stalls", 64'(stall_cnt), 64'd2);

        // DIVU 100/7 with a 32-cycle divider and MFHI waiting behind it
        stall_cnt = 0; div_cnt = 0;
        run_op(OP_DIVU, 32'd100, 32'd7, 32, 2);
        check("t3_hi", 64'(hi_out), 64'd2);
        check("t3_lo", 64'(lo_out), 64'd14);
        check("t3_starts", 64'(div_cnt), 64'd1);
        check("t3_stalls", 64'(stall_cnt), 64'd35);

        // DIV by zero
        stall_cnt = 0; div_cnt = 0;
        run_op(OP_DIV, 32'd5, 32'd0, 0, 0);
        check("t4_hi", 64'(hi_out), 64'd5);
        check("t4_lo", 64'(lo_out), 64'hFFFF_FFFF);
        check("t4_starts", 64'(div_cnt), 64'd0);
        check("t4_stalls", 64'(stall_cnt), 64'd1);

        // Divider never drops busy: timeout
        stall_cnt = 0;
        run_op(OP_DIV, 32'd9, 32'd4, NEVER, 0);
        check("t5_err", 64'(err), 64'd1);
        check("t5_hi", 64'(hi_out), 64'd5);
        check("t5_lo", 64'(lo_out), 64'hFFFF_FFFF);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_stalls", 64'(stall_cnt), 64'd66);

        // Reset in the 10th DIV_WAIT cycle
        cur_div_lat = NEVER;
        op_valid = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd3; rd_hi = 1'b0; rd_lo = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            exp_busy = (k >= 1); exp_stall = 1'b1;
            exp_mul_start = 1'b0; exp_div_start = (k == 1);
            if (k == 11) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0; exp_err = 1'b0;
        idle_cycle(1'b0, 1'b0);
        check("t6_hi", 64'(hi_out), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        repeat (3) idle_cycle(1'b1, 1'b1);
        run_op(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 0, 1);
        check("t6_mul_hi", 64'(hi_out), 64'd3);
        check("t6_mul_lo", 64'(lo_out), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r, dl;
            logic [31:0] a, b;
            r = $urandom_range(0, 9);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            dl = $urandom_range(0, 12);
            if ($urandom_range(0, 19) == 0) dl = DIV_TIMEOUT - 1 + $urandom_range(0, 1);
            if (r < 2) idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else       run_op(3'($urandom_range(0, 7)), a, b, dl, $urandom_range(0, 2));
        end
        idle_cycle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
